// File: rtl/mem_dump_tx.sv
// Snapshots the MEM-stage data-memory bus on request and streams it as a framed
// byte sequence (sync, data MSB-first word 0 first, XOR checksum) over valid/ready.
module mem_dump_tx #(
  parameter int         WORDS  = 10,
  parameter int         WORD_W = 32,
  parameter logic [7:0] SYNC   = 8'hA5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WORDS*WORD_W-1:0] memorias,
  input  logic                    tx_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              word_idx,
  output logic [1:0]              dbgState
);

  // Handshake: a byte moves on a rising edge with tx_valid && tx_ready; while
  // tx_ready is low, tx_valid and tx_data hold; tx_valid never drops before transfer.

  localparam int BPW    = WORD_W / 8;
  localparam int NBYTES = WORDS * BPW;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA, CSUM} state_t;

  state_t                  state, nextState;
  logic [WORDS*WORD_W-1:0] shadowReg;
  logic [CW-1:0]           byteCnt;
  logic [7:0]              csumReg;
  logic [7:0]              dataByte;
  logic                    xfer;
  int                      wordSel;
  int                      byteSel;

  assign xfer     = tx_valid && tx_ready;
  assign dbgState = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    tx_valid  = 1'b0;
    busy      = 1'b0;
    tx_data   = 8'h00;
    word_idx  = 4'd0;
    unique case (state)
      IDLE: begin
        if (start) nextState = HDR;
      end
      HDR: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = SYNC;
        if (xfer) nextState = DATA;
      end
      DATA: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = dataByte;
        word_idx = 4'(wordSel);
        if (xfer && byteCnt == LAST) nextState = CSUM;
      end
      CSUM: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = csumReg;
        if (xfer) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Word 0 sits in the low bits of the bus; bytes within a word go out MSB first.
  always_comb begin
    wordSel  = int'(byteCnt) / BPW;
    byteSel  = BPW - 1 - (int'(byteCnt) % BPW);
    dataByte = shadowReg[wordSel*WORD_W + byteSel*8 +: 8];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadowReg <= '0;
      byteCnt   <= '0;
      csumReg   <= 8'h00;
      done      <= 1'b0;
    end else begin
      done <= (state == CSUM) && xfer;
      if (state == IDLE && start) begin
        shadowReg <= memorias;
        csumReg   <= 8'h00;
        byteCnt   <= '0;
      end
      if (state == HDR && xfer) byteCnt <= '0;
      if (state == DATA && xfer) begin
        csumReg <= csumReg ^ dataByte;
        byteCnt <= byteCnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_dump_tx.sv
// Directed bench for mem_dump_tx: expected frames go into a queue, a negedge
// monitor pops and compares every byte the DUT transfers.
module tb_mem_dump_tx;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [319:0] memorias;
  logic         tx_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         busy;
  logic         done;
  logic [3:0]   word_idx;
  logic [1:0]   dbg_state;

  mem_dump_tx dut (
    .clk(clk), .reset(reset), .start(start), .memorias(memorias),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .busy(busy), .done(done), .word_idx(word_idx), .dbgState(dbg_state)
  );

  always #5 clk = ~clk;

  logic [8:0]  exp_q[$];   // bit 8 marks the checksum byte
  logic [31:0] words[10];
  int          n_vec = 0;
  int          n_fail = 0;
  int          xfer_cnt = 0;
  int          busy_cnt = 0;
  int          pos = 0;
  bit          done_exp = 0;
  bit          prev_stall = 0;
  logic [7:0]  prev_data = 8'h00;
  logic [3:0]  bp_pat = 4'b1001;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words();
    for (int k = 0; k < 10; k++) memorias[k*32 +: 32] = words[k];
  endtask

  task automatic clear_words();
    for (int k = 0; k < 10; k++) words[k] = 32'h0;
  endtask

  task automatic push_frame(input logic [7:0] csum);
    exp_q.push_back({1'b0, 8'hA5});
    for (int k = 0; k < 10; k++)
      for (int b = 3; b >= 0; b--) exp_q.push_back({1'b0, words[k][b*8 +: 8]});
    exp_q.push_back({1'b1, csum});
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_valid", {31'b0, tx_valid}, 32'd1);
    chk("start_busy", {31'b0, busy}, 32'd1);
    chk("start_sync", {24'b0, tx_data}, 32'hA5);
  endtask

  // mode 0: ready high; 1: ready pattern 1,0,0,1; 2: change bus after 3 transfers;
  // 3: extra start pulse at byte 10
  task automatic wait_done(input int mode);
    int base;
    bit got;
    bit sent;
    base = xfer_cnt;
    got  = 0;
    sent = 0;
    for (int c = 0; c < 400; c++) begin
      tx_ready = (mode == 1) ? bp_pat[c % 4] : 1'b1;
      if (mode == 2 && xfer_cnt - base >= 3) memorias = '1;
      start = 1'b0;
      if (mode == 3 && !sent && xfer_cnt - base == 10) begin
        start = 1'b1;
        sent  = 1;
      end
      tick();
      if (done) begin
        got = 1;
        break;
      end
    end
    start    = 1'b0;
    tx_ready = 1'b1;
    chk("done_seen", {31'b0, got}, 32'd1);
    if (!got) begin
      reset = 1'b0;
      exp_q.delete();
      tick();
      reset = 1'b1;
    end
  endtask

  // Monitor: sampled at negedge, inputs only change just after posedge.
  always @(negedge clk) begin
    logic [8:0] ent;
    int         exp_wi;
    if (!reset) begin
      done_exp   = 0;
      pos        = 0;
      prev_stall = 0;
    end else begin
      if (busy) busy_cnt++;
      chk("done", {31'b0, done}, {31'b0, done_exp});
      if (done_exp) chk("done_idle", {30'b0, tx_valid, busy}, 32'd0);
      done_exp = 0;
      if (prev_stall) chk("hold", {23'b0, tx_valid, tx_data}, {24'd1, prev_data});
      exp_wi = (tx_valid && pos >= 1 && pos <= 40) ? (pos - 1) / 4 : 0;
      chk("word_idx", {28'b0, word_idx}, exp_wi);
      if (tx_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {31'b0, tx_valid}, 32'd0);
        end else begin
          chk("byte", {24'b0, tx_data}, {24'b0, exp_q[0][7:0]});
          if (tx_ready) begin
            ent = exp_q.pop_front();
            xfer_cnt++;
            if (ent[8]) begin
              done_exp = 1;
              pos      = 0;
            end else begin
              pos++;
            end
          end
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  initial begin
    int base;
    int bad;
    reset    = 1'b0;
    start    = 1'b0;
    tx_ready = 1'b1;
    memorias = '0;
    clear_words();
    repeat (3) tick();
    chk("rst_outputs", {19'b0, tx_valid, busy, done, word_idx, tx_data}, 32'd0);
    reset = 1'b1;
    tick();

    // Basic frame: word k = k, checksum 0^1^..^9 = 01
    for (int k = 0; k < 10; k++) words[k] = k;
    set_words();
    push_frame(8'h01);
    busy_cnt = 0;
    do_start();
    wait_done(0);
    chk("busy_cycles", busy_cnt, 32'd42);

    // Backpressure: DE^AD^BE^EF = 22
    clear_words();
    words[0] = 32'hDEADBEEF;
    set_words();
    push_frame(8'h22);
    do_start();
    wait_done(1);

    // Snapshot isolation: 40 bytes of 11 -> checksum 00
    for (int k = 0; k < 10; k++) words[k] = 32'h11111111;
    set_words();
    push_frame(8'h00);
    do_start();
    wait_done(2);

    // Start during frame, then start in the done cycle
    clear_words();
    words[3] = 32'h12345678;
    set_words();
    push_frame(8'h08);
    do_start();
    wait_done(3);
    clear_words();
    words[9] = 32'h000000FF;
    set_words();
    push_frame(8'hFF);
    do_start();
    wait_done(0);

    // Asynchronous reset during DATA byte 20
    clear_words();
    words[0] = 32'h80402010;
    set_words();
    push_frame(8'hF0);
    do_start();
    base = xfer_cnt;
    for (int c = 0; c < 100 && xfer_cnt - base < 21; c++) tick();
    chk("mid_word_idx", {28'b0, word_idx}, 32'd5);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst", {25'b0, tx_valid, busy, done, word_idx}, 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (10) tick();
    chk("post_rst_idle", {30'b0, tx_valid, busy}, 32'd0);
    for (int k = 0; k < 10; k++) words[k] = {k[7:0], 24'h0};
    set_words();
    push_frame(8'h01);
    do_start();
    wait_done(0);

    // Idle with ready high, no start
    bad = 0;
    repeat (100) begin
      tick();
      if (tx_valid || done) bad++;
    end
    chk("idle_quiet", bad, 32'd0);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_dump_tx.md
Name: mem_dump_tx

Overview:
- Debug-side reader of the data-memory snapshot bus (`memorias`, 10 words × 32 bits) exported by the MEM stage.
- On a start request it latches the whole bus into a shadow register and streams it out as a framed byte sequence: sync byte, data bytes, XOR checksum.
- Output uses a valid/ready handshake and feeds the UART transmitter of the debug unit.
- The snapshot isolates the dump from memory writes made while the pipeline keeps running.

Parameters:
- WORDS, 10, number of 32-bit words on the snapshot bus.
- WORD_W, 32, bits per word; must be a multiple of 8.
- SYNC, 8'hA5, header byte sent before the data.

Ports:
- clk, input, 1, system clock; all registers update on the rising edge.
- reset, input, 1, asynchronous, active-low reset (0 = reset asserted).
- start, input, 1, dump request; sampled on the rising edge; honoured only in IDLE.
- memorias, input, WORDS*WORD_W, snapshot bus; word k occupies bits [k*32+31:k*32].
- tx_ready, input, 1, downstream can accept a byte this cycle.
- tx_data, output, 8, byte being offered.
- tx_valid, output, 1, tx_data is valid.
- busy, output, 1, frame in progress (any state other than IDLE).
- done, output, 1, one-cycle pulse after the checksum byte is accepted.
- word_idx, output, 4, index of the word currently being sent; 0 outside DATA.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - tx_data, tx_valid, busy, done, word_idx all go to 0.
  - Shadow register, byte counter and checksum clear to 0.
  - Applies immediately, including mid-frame. The partial frame is abandoned and is not resumed after release.
- States: IDLE, HDR, DATA, CSUM.
- IDLE:
  - tx_valid=0, busy=0.
  - start=1 at edge N: capture memorias into the shadow register, clear checksum, move to HDR.
  - At N+1: tx_valid=1, tx_data=SYNC, busy=1.
- Handshake:
  - A byte transfers on a rising edge where tx_valid=1 and tx_ready=1.
  - While tx_ready=0, tx_data and tx_valid hold stable.
  - tx_valid never drops before the transfer completes.
  - After a transfer, the next byte (if any) is presented in the following cycle. Back-to-back transfers are allowed, giving a throughput of 1 byte/cycle when tx_ready is held high.
- HDR: on transfer, go to DATA with byte_cnt=0.
- DATA:
  - byte_cnt runs 0 to WORDS*4-1 (0..39).
  - Word order: word 0 first.
  - Byte order within a word: most-significant byte first (bits 31:24, 23:16, 15:8, 7:0).
  - word_idx = byte_cnt/4.
  - Each transferred data byte is XORed into the checksum. SYNC is not included in the checksum.
  - Transfer of byte 39 moves to CSUM.
- CSUM:
  - tx_data = XOR of all 40 data bytes.
  - On transfer: return to IDLE and assert done=1 for exactly the next cycle; tx_valid=0 and busy=0 in that cycle.
- start while busy: ignored; no queuing.
- start asserted in the done cycle: accepted, since the state is already IDLE; a new capture occurs.
- Changes on memorias after the capture edge do not affect the frame in progress.
- Frame length is always 1 + WORDS*4 + 1 = 42 bytes.
- Minimum start-to-done latency with tx_ready held at 1: done is high at edge N+43.

Test Plan:
- Basic frame:
  - Stimulus: reset pulse; memorias word k = 32'h0000_0000 + k; tx_ready=1; start pulse.
  - Required: bytes A5, then 00 00 00 00, 00 00 00 01 … 00 00 00 09, then checksum 8'h01. done one cycle after the 42nd transfer; busy high for exactly 42 cycles.
- Backpressure:
  - Stimulus: word 0 = 32'hDEADBEEF, other words 0; tx_ready toggled 1,0,0,1 repeating.
  - Required: tx_data holds each value while tx_ready=0; byte sequence A5 DE AD BE EF 00…; checksum = DE^AD^BE^EF = 8'h22.
- Snapshot isolation:
  - Stimulus: start with all words = 32'h11111111; change memorias to all 32'hFFFFFFFF after 3 transfers.
  - Required: all 40 data bytes = 8'h11; checksum = 8'h00.
- start during frame:
  - Stimulus: pulse start at byte 10, then again in the done cycle.
  - Required: first extra pulse ignored (still exactly 42 bytes); second pulse starts a new frame with A5 on the next cycle.
- Asynchronous reset mid-frame:
  - Stimulus: drive reset=0 between clock edges during DATA byte 20.
  - Required: tx_valid, busy, word_idx go to 0 without waiting for a clock edge; after release, no output until a new start, and the new frame begins with A5.
- Idle with tx_ready=1 and no start:
  - Required: tx_valid stays 0 and done never pulses over 100 cycles.
